// File: rtl/prot_pkg.sv
// prot_pkg: shared state encoding, fault bit indices and helpers for the
// protection sequencer.
package prot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ON    = 3'd1,
    ST_DSCHG = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LOCK  = 3'd4
  } prot_state_t;

  localparam int unsigned FLT_UVP   = 0;
  localparam int unsigned FLT_OCP   = 1;
  localparam int unsigned FLT_OVP   = 2;
  localparam int unsigned FLT_OTP   = 3;
  localparam int unsigned FLT_SCP   = 4;
  localparam int unsigned FLT_V5OCP = 5;
  localparam int unsigned FLT_CDOVP = 6;
  localparam int unsigned FLT_DNFLT = 7;

  localparam logic [2:0] RETRY_INF = 3'd7;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lsb_idx(input logic [7:0] v);
    lsb_idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) lsb_idx = 3'(i - 1);
    end
  endfunction

endpackage

// File: rtl/prot_tmr.sv
// prot_tmr: tick-gated 8-bit down-counter; load wins over a same-cycle tick,
// expire flags a tick arriving while the count is already zero.
module prot_tmr (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] ld_val,
  output logic       expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ld_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = tick && (cnt == '0);

endmodule

// File: rtl/prot_seq.sv
// prot_seq: fault status latching plus trip / discharge / hiccup / latch-off
// sequencing of the power switch. Optional first-fault log: PROT_FLTLOG_EN.
module prot_seq
  import prot_pkg::*;
#(
  parameter int unsigned N_FLT    = 8,
  parameter int unsigned DSCHG_TK = 4,
  parameter int unsigned BLANK_TK = 8,
  parameter int unsigned RCLR_TK  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [N_FLT-1:0] i_flt,
  input  logic [N_FLT-1:0] i_trip_msk,
  input  logic [N_FLT-1:0] i_ie,
  input  logic [N_FLT-1:0] i_clr,
  input  logic             i_sw_en,
  input  logic [7:0]       i_retry_tk,
  input  logic [2:0]       i_retry_max,
  output logic [N_FLT-1:0] o_sts,
  output logic             o_irq,
  output logic             o_gate,
  output logic             o_dis,
  output logic             o_lock,
  output logic [2:0]       o_state,
  output logic [2:0]       o_rcnt,
  output logic [2:0]       o_first,
  output logic             o_first_vld
);

  localparam int unsigned RCW = $clog2(RCLR_TK + 1);

  prot_state_t      state, nstate;
  logic [N_FLT-1:0] flt_q, blank_msk, trip_vec;
  logic [7:0]       bcnt, tmr_val, rtk_ld;
  logic [RCW-1:0]   rcc;
  logic             rsn_flt, blank_act, trip, lock_due;
  logic             tmr_load, tmr_exp, reload, rcnt_inc, lock_exit, rc_done;

  // Status: rising-edge set, write-1 clear, set dominates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flt_q <= '0;
      o_sts <= '0;
      o_irq <= 1'b0;
    end else begin
      flt_q <= i_flt;
      o_sts <= (o_sts & ~i_clr) | (i_flt & ~flt_q);
      o_irq <= |(o_sts & i_ie);
    end
  end

  // UVP is ignored only while the post-turn-on blank window is running.
  assign blank_act = (state == ST_ON) && (bcnt != '0);
  always_comb begin
    blank_msk          = '1;
    blank_msk[FLT_UVP] = ~blank_act;
  end
  assign trip_vec = i_flt & i_trip_msk & blank_msk;
  assign trip     = |trip_vec;

  assign rtk_ld   = (i_retry_tk == '0) ? 8'd0 : i_retry_tk - 8'd1;
  assign lock_due = (i_retry_max == '0) ||
                    ((i_retry_max != RETRY_INF) && (o_rcnt > i_retry_max));

  always_comb begin
    nstate    = state;
    reload    = 1'b0;
    rcnt_inc  = 1'b0;
    lock_exit = 1'b0;
    case (state)
      ST_IDLE:  if (i_sw_en && !trip) nstate = ST_ON;
      ST_ON: begin
        if (trip) begin
          nstate   = ST_DSCHG;
          rcnt_inc = 1'b1;
        end else if (!i_sw_en) begin
          nstate = ST_DSCHG;
        end
      end
      ST_DSCHG: begin
        if (tmr_exp) begin
          if (!rsn_flt)      nstate = ST_IDLE;
          else if (lock_due) nstate = ST_LOCK;
          else               nstate = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_sw_en)      nstate = ST_IDLE;
        else if (tmr_exp) begin
          if (trip) reload = 1'b1;
          else      nstate = ST_ON;
        end
      end
      ST_LOCK: begin
        if (!i_sw_en) begin
          nstate    = ST_IDLE;
          lock_exit = 1'b1;
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // Timer loads N-1 so that expiry lands on the Nth tick after entry.
  always_comb begin
    tmr_val = '0;
    case (nstate)
      ST_DSCHG: tmr_val = 8'(DSCHG_TK - 1);
      ST_WAIT:  tmr_val = rtk_ld;
      default:  tmr_val = '0;
    endcase
  end
  assign tmr_load = (nstate != state) || reload;

  prot_tmr u_tmr (
    .clk    (i_clk),
    .rst    (i_rst),
    .tick   (i_tick),
    .load   (tmr_load),
    .ld_val (tmr_val),
    .expire (tmr_exp)
  );

  assign rc_done = (state == ST_ON) && i_tick && (rcc == RCW'(RCLR_TK - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      rsn_flt <= 1'b0;
      bcnt    <= '0;
      rcc     <= '0;
      o_rcnt  <= '0;
      o_gate  <= 1'b0;
      o_dis   <= 1'b0;
      o_lock  <= 1'b0;
    end else begin
      state  <= nstate;
      o_gate <= (nstate == ST_ON);
      o_dis  <= (nstate == ST_DSCHG);
      o_lock <= (nstate == ST_LOCK);
      if ((state == ST_ON) && (nstate == ST_DSCHG)) rsn_flt <= trip;
      if ((nstate == ST_ON) && (state != ST_ON)) begin
        bcnt <= 8'(BLANK_TK);
      end else if ((state == ST_ON) && i_tick && (bcnt != '0)) begin
        bcnt <= bcnt - 8'd1;
      end
      if (state != ST_ON) begin
        rcc <= '0;
      end else if (i_tick && (rcc != RCW'(RCLR_TK))) begin
        rcc <= rcc + 1'b1;
      end
      if (rcnt_inc) begin
        if (o_rcnt != 3'd7) o_rcnt <= o_rcnt + 3'd1;
      end else if (lock_exit || rc_done) begin
        o_rcnt <= '0;
      end
    end
  end

  assign o_state = state;

`ifdef PROT_FLTLOG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_first     <= '0;
      o_first_vld <= 1'b0;
    end else if (o_first_vld) begin
      if (i_clr[o_first] || lock_exit) o_first_vld <= 1'b0;
    end else if ((state == ST_ON) && trip) begin
      o_first     <= lsb_idx(8'(trip_vec));
      o_first_vld <= 1'b1;
    end
  end
`else
  assign o_first     = '0;
  assign o_first_vld = 1'b0;
`endif

endmodule

// File: tb/tb_prot_seq.sv
// tb_prot_seq: status table, randomized status/irq against a bit-level model,
// and hand-written sequences for trip, hiccup, blanking, lock and reset.
module tb_prot_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_tick, i_sw_en;
  logic [7:0] i_flt, i_trip_msk, i_ie, i_clr, i_retry_tk;
  logic [2:0] i_retry_max;
  logic [7:0] o_sts;
  logic       o_irq, o_gate, o_dis, o_lock, o_first_vld;
  logic [2:0] o_state, o_rcnt, o_first;

  prot_seq dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_tick      (i_tick),
    .i_flt       (i_flt),
    .i_trip_msk  (i_trip_msk),
    .i_ie        (i_ie),
    .i_clr       (i_clr),
    .i_sw_en     (i_sw_en),
    .i_retry_tk  (i_retry_tk),
    .i_retry_max (i_retry_max),
    .o_sts       (o_sts),
    .o_irq       (o_irq),
    .o_gate      (o_gate),
    .o_dis       (o_dis),
    .o_lock      (o_lock),
    .o_state     (o_state),
    .o_rcnt      (o_rcnt),
    .o_first     (o_first),
    .o_first_vld (o_first_vld)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_sts, m_fq;
  logic       m_irq;

  typedef struct {
    logic [7:0] flt;
    logic [7:0] clr;
    logic [7:0] ie;
    logic [7:0] sts;
    logic       irq;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; the status model advances from the inputs applied this cycle.
  task automatic cyc();
    logic [7:0] nsts;
    logic       nirq;
    nirq = |(m_sts & i_ie);
    nsts = m_sts;
    for (int b = 0; b < 8; b++) begin
      if (i_clr[b]) nsts[b] = 1'b0;
      if (i_flt[b] && !m_fq[b]) nsts[b] = 1'b1;
    end
    m_fq = i_flt;
    @(posedge i_clk);
    #1;
    m_sts = nsts;
    m_irq = nirq;
  endtask

  // Gap cycle followed by a tick cycle; returns just after the tick edge.
  task automatic tk();
    i_tick = 1'b0;
    cyc();
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
  endtask

  task automatic tks(input int n);
    for (int j = 0; j < n; j++) tk();
  endtask

  task automatic do_reset(input string name);
    i_rst = 1'b1;
    #2;
    chk(name, {o_sts, o_irq, o_gate, o_dis, o_lock, o_state, o_rcnt, o_first_vld, o_first}, 32'd0);
    i_tick = 1'b0; i_sw_en = 1'b0; i_flt = '0; i_trip_msk = '0; i_ie = '0; i_clr = '0;
    i_retry_tk = '0; i_retry_max = '0;
    m_sts = '0; m_fq = '0; m_irq = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{8'h00, 8'h00, 8'h02, 8'h00, 1'b0};
    tbl[1]  = '{8'h02, 8'h00, 8'h02, 8'h02, 1'b0};
    tbl[2]  = '{8'h00, 8'h00, 8'h02, 8'h02, 1'b1};
    tbl[3]  = '{8'h04, 8'h04, 8'h02, 8'h06, 1'b1};
    tbl[4]  = '{8'h04, 8'h00, 8'h02, 8'h06, 1'b1};
    tbl[5]  = '{8'h00, 8'h02, 8'h02, 8'h04, 1'b1};
    tbl[6]  = '{8'h00, 8'h00, 8'h02, 8'h04, 1'b0};
    tbl[7]  = '{8'h00, 8'h00, 8'h04, 8'h04, 1'b1};
    tbl[8]  = '{8'h80, 8'h04, 8'h00, 8'h80, 1'b0};
    tbl[9]  = '{8'h80, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 8'h80, 8'h00, 1'b0};

    do_reset("rst_init");

    for (int r = 0; r < 11; r++) begin
      i_flt = tbl[r].flt; i_clr = tbl[r].clr; i_ie = tbl[r].ie;
      cyc();
      chk($sformatf("tbl_sts[%0d]", r), o_sts, tbl[r].sts);
      chk($sformatf("tbl_irq[%0d]", r), o_irq, tbl[r].irq);
    end

    for (int r = 0; r < 300; r++) begin
      i_flt = 8'($urandom);
      i_clr = 8'($urandom & $urandom & $urandom);
      i_ie  = 8'($urandom);
      cyc();
      chk("rand_sts", o_sts, m_sts);
      chk("rand_irq", o_irq, m_irq);
    end
    i_flt = '0; i_clr = '0; i_ie = '0;

    // Hiccup: two retries then latch-off on the third trip.
    do_reset("rst_hiccup");
    i_trip_msk = 8'hFF; i_retry_max = 3'd2; i_retry_tk = 8'd5; i_sw_en = 1'b1;
    cyc();
    chk("hic_on", {o_state, o_gate, o_dis}, {3'd1, 1'b1, 1'b0});
    for (int k = 1; k <= 3; k++) begin
      i_flt = 8'h02;
      cyc();
      chk("hic_trip", {o_state, o_gate, o_dis, o_rcnt}, {3'd2, 1'b0, 1'b1, 3'(k)});
      i_flt = 8'h00;
      tks(3);
      chk("hic_dis_hold", {o_state, o_dis}, {3'd2, 1'b1});
      tk();
      if (k < 3) begin
        chk("hic_wait", {o_state, o_gate, o_dis}, {3'd3, 1'b0, 1'b0});
        tks(4);
        chk("hic_wait_hold", o_state, 3'd3);
        tk();
        chk("hic_reon", {o_state, o_gate}, {3'd1, 1'b1});
      end else begin
        chk("hic_lock", {o_state, o_lock, o_rcnt, o_gate}, {3'd4, 1'b1, 3'd3, 1'b0});
      end
    end
    i_sw_en = 1'b0;
    cyc();
    chk("hic_unlock", {o_state, o_lock, o_rcnt}, {3'd0, 1'b0, 3'd0});

    // UVP blanking after turn-on.
    do_reset("rst_uvp");
    i_trip_msk = 8'hFF; i_retry_max = 3'd7; i_retry_tk = 8'd1; i_sw_en = 1'b1;
    cyc();
    chk("uvp_on", o_state, 3'd1);
    i_flt = 8'h01;
    tks(6);
    chk("uvp_blank6", o_state, 3'd1);
    i_flt = 8'h00;
    tks(4);
    chk("uvp_noTrip", {o_state, o_rcnt, o_sts[0]}, {3'd1, 3'd0, 1'b1});
    i_sw_en = 1'b0;
    cyc();
    tks(4);
    chk("uvp_normal_off", o_state, 3'd0);
    i_sw_en = 1'b1;
    cyc();
    i_flt = 8'h01;
    tks(7);
    chk("uvp_blank7", o_state, 3'd1);
    tk();
    chk("uvp_blank8", o_state, 3'd1);
    cyc();
    chk("uvp_trip", {o_state, o_rcnt}, {3'd2, 3'd1});
    i_flt = 8'h00;

    // Retry counter clears after RCLR ticks fault-free; retry_tk=0 acts as 1.
    do_reset("rst_rcc");
    i_trip_msk = 8'h02; i_retry_max = 3'd7; i_retry_tk = 8'd0; i_sw_en = 1'b1;
    cyc();
    i_flt = 8'h02;
    cyc();
    chk("rcc_trip", {o_state, o_rcnt}, {3'd2, 3'd1});
    i_flt = 8'h00;
    tks(4);
    chk("rcc_wait", o_state, 3'd3);
    tk();
    chk("rcc_reon_tk0", o_state, 3'd1);
    tks(63);
    chk("rcc_63", {o_state, o_rcnt}, {3'd1, 3'd1});
    tk();
    chk("rcc_64", {o_state, o_rcnt}, {3'd1, 3'd0});

    // Trip and switch-off together: fault wins; retry_max=0 locks.
    i_retry_max = 3'd0; i_flt = 8'h02; i_sw_en = 1'b0;
    cyc();
    chk("sim_fault", {o_state, o_rcnt}, {3'd2, 3'd1});
    i_flt = 8'h00;
    tks(4);
    chk("sim_lock", {o_state, o_lock}, {3'd4, 1'b1});
    cyc();
    chk("lock_exit", {o_state, o_rcnt, o_lock}, {3'd0, 3'd0, 1'b0});

    // Asynchronous reset in the middle of discharge.
    do_reset("rst_ar");
    i_sw_en = 1'b1;
    cyc();
    i_sw_en = 1'b0;
    cyc();
    chk("ar_dis", {o_state, o_dis}, {3'd2, 1'b1});
    tk();
    do_reset("ar_reset_midseq");
    cyc();
    chk("ar_idle", {o_state, o_gate, o_dis}, {3'd0, 1'b0, 1'b0});

    // First-fault log.
    do_reset("rst_first");
    i_trip_msk = 8'hFF; i_retry_max = 3'd7; i_retry_tk = 8'd1; i_sw_en = 1'b1;
    cyc();
    i_flt = 8'h14;
    cyc();
`ifdef PROT_FLTLOG_EN
    chk("first_cap", {o_first_vld, o_first}, {1'b1, 3'd2});
    i_flt = 8'h00;
    tks(4);
    tk();
    chk("first_reon", o_state, 3'd1);
    i_flt = 8'h02;
    cyc();
    chk("first_keep", {o_first_vld, o_first}, {1'b1, 3'd2});
    i_flt = 8'h00; i_clr = 8'h04;
    cyc();
    i_clr = 8'h00;
    chk("first_clr", o_first_vld, 1'b0);
`else
    chk("first_tied", {o_state, o_first_vld, o_first}, {3'd2, 1'b0, 3'd0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prot_seq.md
Name: prot_seq

Overview:
- Protection response sequencer behind the fault debouncers.
- Takes the eight debounced fault levels (same bit map as the fault status register) and latches them into write-1-clear status with an interrupt.
- Drives the power-switch gate and discharge enables.
- Runs trip, discharge, hiccup-retry and latch-off sequencing on a 1 ms tick from the shared prescaler.

Parameters:
- N_FLT, 8, number of fault inputs; bit map 0 UVP, 1 OCP, 2 OVP, 3 OTP/CF, 4 SCP, 5 V5OCP, 6 CDOVP, 7 DN_FAULT.
- DSCHG_TK, 4, discharge duration in ticks.
- BLANK_TK, 8, UVP blanking after gate turn-on, in ticks.
- RCLR_TK, 64, fault-free ON ticks that clear the retry counter.

Ports:
- i_clk  in  1  system clock, 12 MHz.
- i_rst  in  1  asynchronous active-high reset.
- i_tick  in  1  1 ms timebase strobe, one i_clk wide.
- i_flt  in  N_FLT  debounced fault levels, synchronous to i_clk.
- i_trip_msk  in  N_FLT  1 = fault bit causes a trip.
- i_ie  in  N_FLT  interrupt enable per status bit.
- i_clr  in  N_FLT  write-1-clear strobe from the regbank.
- i_sw_en  in  1  firmware switch-on request.
- i_retry_tk  in  8  hiccup off-time in ticks; 0 is treated as 1.
- i_retry_max  in  3  0 = latch-off on first trip; 1..6 = retries allowed; 7 = unlimited.
- o_sts  out  N_FLT  latched fault status.
- o_irq  out  1  registered, = |(o_sts & i_ie).
- o_gate  out  1  power-switch enable.
- o_dis  out  1  discharge enable.
- o_lock  out  1  latch-off indicator.
- o_state  out  3  FSM state, for debug and the regbank.
- o_rcnt  out  3  retry counter.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; the i_flt edge register is cleared to 0.
- Status bits:
  - o_sts[i] sets on the rising edge of i_flt[i], detected against a 1-cycle registered copy; this is independent of i_trip_msk.
  - i_clr[i] clears o_sts[i].
  - A set and a clear in the same cycle: set wins.
  - o_irq follows o_sts with 1 cycle of latency.
- Trip condition: trip = |(i_flt & i_trip_msk & blank).
  - blank is all-ones except bit 0, which reads 0 while the blank counter is nonzero.
  - Trip is level based, not edge based.
- Timer:
  - A single shared tick counter is loaded on each state entry.
  - It decrements only on i_tick.
  - A tick in the entry cycle is not counted.
  - Expiry occurs when the counter is 0 and i_tick is high.
- IDLE: gate=0, dis=0.
  - Go to ON when i_sw_en=1 and trip=0, evaluated with blank inactive.
  - Entering ON loads the blank counter with BLANK_TK.
- ON: gate=1.
  - trip=1 → DSCHG with reason=fault; o_rcnt increments, saturating at 7.
  - Otherwise, i_sw_en=0 → DSCHG with reason=normal.
  - Trip has priority when both occur in the same cycle.
  - The RCLR counter counts ticks in ON; when it reaches RCLR_TK, o_rcnt is cleared.
- DSCHG: gate=0, dis=1 for DSCHG_TK ticks. On expiry:
  - reason=normal → IDLE.
  - reason=fault and (i_retry_max=0, or i_retry_max≠7 and o_rcnt>i_retry_max) → LOCK.
  - Otherwise → WAIT.
- WAIT: gate=0, dis=0, counting i_retry_tk ticks.
  - i_sw_en=0 at any time → IDLE.
  - On expiry with trip=0 → ON.
  - On expiry with trip=1 → reload and stay in WAIT; o_rcnt is not incremented.
- LOCK: o_lock=1, gate=0.
  - Exit to IDLE only when i_sw_en=0; the exit clears o_rcnt.
- Gate timing: o_gate and o_dis are registered outputs. o_gate never goes high in the same cycle o_dis is high.
- Reset mid-sequence: gate and dis drop immediately (asynchronous); the FSM returns to IDLE.

Optional Feature:
- PROT_FLTLOG_EN defined:
  - Adds o_first[2:0] and o_first_vld.
  - On the first trip since the last LOCK exit or i_clr of that bit, capture the lowest-index asserted bit of the trip vector and set o_first_vld.
  - Later trips do not overwrite it.
  - i_clr at the captured index clears o_first_vld.
- Undefined: both outputs tied to 0; no capture logic.

Decomposition:
- Package prot_pkg holds:
  - State encoding: IDLE=0, ON=1, DSCHG=2, WAIT=3, LOCK=4.
  - Fault index constants FLT_UVP..FLT_DNFLT.
  - RETRY_INF=7.
- One sub-module, prot_tmr: tick-gated 8-bit down-counter with load and expire outputs. It is instanced once for the state timer.
- The blank and RCLR counters are inline.

Test Plan:
- Status and interrupt: i_ie=0x02, pulse i_flt[1] → o_sts=0x02, o_irq=1 one cycle later. A same-cycle i_flt[2] rise with i_clr=0x04 → bit 2 set.
- Hiccup retry: i_retry_max=2, i_retry_tk=5, OCP held high.
  - ON→DSCHG (o_dis high 4 ticks)→WAIT (5 ticks)→ON, twice.
  - The third trip → LOCK with o_rcnt=3.
  - i_sw_en=0 → IDLE, o_rcnt=0.
- UVP blanking: UVP high at turn-on for 6 ticks then low → no trip. UVP high for 10 ticks → trip at the tick after the 8th.
- Retry counter clear: after one trip, stay fault-free 64 ticks in ON → o_rcnt returns from 1 to 0.
- Simultaneous events: trip and i_sw_en fall in the same cycle → reason=fault. i_retry_max=0 → LOCK after DSCHG.
- Async reset: assert i_rst in DSCHG → o_dis=0 immediately, o_state=0.
- (PROT_FLTLOG_EN) OVP and SCP trip together → o_first=2, o_first_vld=1.
